// File: rtl/mem_bus_arbiter_if.sv
// Bundles the core-side fetch/data ports and the shared memory bus.
// The master modport is the arbiter's view; slave is the core/memory side.
interface mem_bus_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [3:0]       d_byteen;
  logic [WIDTH-1:0] d_rdata;
  logic             d_ack;

  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_rdata;
  logic             i_ack;

  logic             err;

  logic             m_req;
  logic             m_we;
  logic [WIDTH-1:0] m_addr;
  logic [WIDTH-1:0] m_wdata;
  logic [3:0]       m_byteen;
  logic [WIDTH-1:0] m_rdata;
  logic             m_ack;

  modport master (
    input  d_req, d_we, d_addr, d_wdata, d_byteen,
    output d_rdata, d_ack,
    input  i_req, i_addr,
    output i_rdata, i_ack,
    output err,
    output m_req, m_we, m_addr, m_wdata, m_byteen,
    input  m_rdata, m_ack
  );

  modport slave (
    output d_req, d_we, d_addr, d_wdata, d_byteen,
    input  d_rdata, d_ack,
    output i_req, i_addr,
    input  i_rdata, i_ack,
    input  err,
    input  m_req, m_we, m_addr, m_wdata, m_byteen,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and data ports,
// with registered request latching, ack-based handshake and a per-transaction timeout.
module mem_bus_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [31:0] CntLast   = 32'(TIMEOUT - 1);

  state_e           state_q, state_d;
  // Current owner of the bus; also the round-robin "last grant" (1 = data port).
  logic             gnt_data_q, gnt_data_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [3:0]       m_byteen_q, m_byteen_d;

  logic             d_ack_q, d_ack_d;
  logic             i_ack_q, i_ack_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;

  logic             data_win;
  logic             timed_out;

  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    cnt_d      = cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_byteen_d = m_byteen_q;
    d_ack_d    = 1'b0;
    i_ack_d    = 1'b0;
    err_d      = 1'b0;
    d_rdata_d  = d_rdata_q;
    i_rdata_d  = i_rdata_q;
    data_win   = 1'b0;
    timed_out  = TimeoutEn && (cnt_q == CntLast);

    unique case (state_q)
      StIdle: begin
        if (bus.d_req || bus.i_req) begin
          // Data wins a conflict unless it was the previous owner.
          data_win   = bus.d_req && (!bus.i_req || !gnt_data_q);
          gnt_data_d = data_win;
          if (data_win) begin
            m_we_d     = bus.d_we;
            m_addr_d   = bus.d_addr;
            m_wdata_d  = bus.d_wdata;
            m_byteen_d = bus.d_byteen;
          end else begin
            m_we_d     = 1'b0;
            m_addr_d   = bus.i_addr;
            m_wdata_d  = '0;
            m_byteen_d = 4'b1111;
          end
          m_req_d = 1'b1;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.m_ack || timed_out) begin
          m_req_d = 1'b0;
          state_d = StDone;
          // Ack takes priority over a coinciding timeout.
          err_d   = !bus.m_ack;
          if (gnt_data_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = (bus.m_ack && !m_we_q) ? bus.m_rdata : '0;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.m_ack ? bus.m_rdata : '0;
          end
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_data_q <= 1'b0;
      cnt_q      <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_byteen_q <= '0;
      d_ack_q    <= 1'b0;
      i_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      d_rdata_q  <= '0;
      i_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      cnt_q      <= cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_byteen_q <= m_byteen_d;
      d_ack_q    <= d_ack_d;
      i_ack_q    <= i_ack_d;
      err_q      <= err_d;
      d_rdata_q  <= d_rdata_d;
      i_rdata_q  <= i_rdata_d;
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_byteen = m_byteen_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.i_ack    = i_ack_q;
  assign bus.err      = err_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_rdata  = i_rdata_q;

endmodule
